execute_stage_pipe: RTL

//  Parametrised execute stage: operand forwarding muxes, ALU, CNZ flag register, branch resolve, EX/MEM output register.

---
 rtl/execute_stage_pipe_if.sv | 51 +++++
 rtl/execute_stage_pipe.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage_pipe_if.sv
// Bundle between decode, the execute stage and the memory stage.
// The master side drives operands and consumes results; the execute stage is the slave.
interface execute_stage_pipe_if #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 32,
  parameter int CTRL_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic [1:0]        fwd_sel_a;
  logic [1:0]        fwd_sel_b;
  logic [DATA_W-1:0] rdest_data;
  logic [DATA_W-1:0] rsrc_data;
  logic [DATA_W-1:0] exmem_fwd_data;
  logic [DATA_W-1:0] wb_fwd_data;
  logic [DATA_W-1:0] imm;
  logic [3:0]        alu_op;
  logic              flag_we;
  logic              flag_restore;
  logic [2:0]        flag_restore_val;
  logic [2:0]        jump_sel;
  logic [PC_W-1:0]   pc;
  logic [CTRL_W-1:0] ctrl_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result_out;
  logic [DATA_W-1:0] result_hi_out;
  logic [2:0]        flags_out;
  logic              branch_taken;
  logic [PC_W-1:0]   branch_target;
  logic [PC_W-1:0]   pc_out;
  logic [CTRL_W-1:0] ctrl_out;
  logic              busy;

  modport master (
    output in_valid, flush, fwd_sel_a, fwd_sel_b, rdest_data, rsrc_data,
           exmem_fwd_data, wb_fwd_data, imm, alu_op, flag_we, flag_restore,
           flag_restore_val, jump_sel, pc, ctrl_in, out_ready,
    input  in_ready, out_valid, result_out, result_hi_out, flags_out,
           branch_taken, branch_target, pc_out, ctrl_out, busy
  );

  modport slave (
    input  in_valid, flush, fwd_sel_a, fwd_sel_b, rdest_data, rsrc_data,
           exmem_fwd_data, wb_fwd_data, imm, alu_op, flag_we, flag_restore,
           flag_restore_val, jump_sel, pc, ctrl_in, out_ready,
    output in_ready, out_valid, result_out, result_hi_out, flags_out,
           branch_taken, branch_target, pc_out, ctrl_out, busy
  );
endinterface

// File: rtl/execute_stage_pipe.sv
// Execute stage: forwarding muxes, ALU, {C,N,Z} flag register, branch resolve,
// multi-cycle multiplier and a valid/ready EX/MEM output register.
//
//   state  | meaning
//   IDLE   | accepting instructions, single-cycle ops complete on accept
//   MUL    | multiply in progress, counter runs down to 0 then result loads
module execute_stage_pipe #(
  parameter int DATA_W  = 16,
  parameter int PC_W    = 32,
  parameter int CTRL_W  = 16,
  parameter int MUL_LAT = 4
) (
  input logic                 clk,
  input logic                 reset,
  execute_stage_pipe_if.slave bus
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;
  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  localparam logic [3:0] OP_MOV  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_INC  = 4'h6;
  localparam logic [3:0] OP_DEC  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_SETC = 4'hA;
  localparam logic [3:0] OP_CLRC = 4'hB;
  localparam logic [3:0] OP_MUL  = 4'hC;

  localparam logic [DATA_W:0] ONE_X = {{DATA_W{1'b0}}, 1'b1};

  logic [0:0]          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [2:0]          flags_q, flags_d;
  logic                out_valid_q;
  logic [DATA_W-1:0]   result_q, result_hi_q;
  logic                taken_q;
  logic [PC_W-1:0]     target_q, pc_q;
  logic [CTRL_W-1:0]   ctrl_q;

  logic [DATA_W-1:0]   mul_a_q, mul_b_q;
  logic                mul_fwe_q, mul_taken_q;
  logic [2:0]          mul_clr_q;
  logic [PC_W-1:0]     mul_target_q, mul_pc_q;
  logic [CTRL_W-1:0]   mul_ctrl_q;

  logic [DATA_W-1:0]   opa, opb, alu_res;
  logic                alu_c;
  logic [DATA_W:0]     wide;
  logic [4:0]          sh;
  logic [2*DATA_W-1:0] prod;
  logic                is_mul, is_nop, accept, in_ready, mul_done, taken;
  logic [2:0]          clr_now;

  always_comb begin
    case (bus.fwd_sel_a)
      2'b01:   opa = bus.exmem_fwd_data;
      2'b10:   opa = bus.wb_fwd_data;
      default: opa = bus.rdest_data;
    endcase
    case (bus.fwd_sel_b)
      2'b01:   opb = bus.exmem_fwd_data;
      2'b10:   opb = bus.wb_fwd_data;
      2'b11:   opb = bus.imm;
      default: opb = bus.rsrc_data;
    endcase
  end

  assign sh = opb[4:0];

  // Carry defaults to the current C so logic ops leave it untouched.
  always_comb begin
    alu_res = '0;
    alu_c   = flags_q[2];
    wide    = '0;
    case (bus.alu_op)
      OP_MOV: alu_res = opb;
      OP_ADD: begin wide = {1'b0, opa} + {1'b0, opb}; alu_res = wide[DATA_W-1:0]; alu_c = wide[DATA_W]; end
      OP_SUB: begin wide = {1'b0, opa} - {1'b0, opb}; alu_res = wide[DATA_W-1:0]; alu_c = wide[DATA_W]; end
      OP_AND: alu_res = opa & opb;
      OP_OR:  alu_res = opa | opb;
      OP_NOT: alu_res = ~opa;
      OP_INC: begin wide = {1'b0, opa} + ONE_X; alu_res = wide[DATA_W-1:0]; alu_c = wide[DATA_W]; end
      OP_DEC: begin wide = {1'b0, opa} - ONE_X; alu_res = wide[DATA_W-1:0]; alu_c = wide[DATA_W]; end
      OP_SHL: begin
        wide    = {1'b0, opa} << sh;
        alu_res = wide[DATA_W-1:0];
        if (sh != 5'd0) alu_c = wide[DATA_W];
      end
      OP_SHR: begin
        wide    = {opa, 1'b0} >> sh;
        alu_res = wide[DATA_W:1];
        if (sh != 5'd0) alu_c = wide[0];
      end
      OP_SETC: begin alu_res = opa; alu_c = 1'b1; end
      OP_CLRC: begin alu_res = opa; alu_c = 1'b0; end
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    taken   = 1'b0;
    clr_now = 3'b000;
    case (bus.jump_sel)
      3'b001: begin taken = flags_q[0]; clr_now = flags_q[0] ? 3'b001 : 3'b000; end
      3'b010: begin taken = flags_q[1]; clr_now = flags_q[1] ? 3'b010 : 3'b000; end
      3'b011: begin taken = flags_q[2]; clr_now = flags_q[2] ? 3'b100 : 3'b000; end
      3'b100: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  assign is_mul   = (bus.alu_op == OP_MUL);
  assign is_nop   = (bus.alu_op > OP_MUL);
  assign prod     = {{DATA_W{1'b0}}, mul_a_q} * {{DATA_W{1'b0}}, mul_b_q};
  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready) && !bus.flush;
  assign accept   = bus.in_valid && in_ready;
  assign mul_done = (state_q == S_MUL) && (cnt_q == '0) && (!out_valid_q || bus.out_ready) && !bus.flush;

  // Flag update first, then the taken-branch clear, and a restore overrides both.
  always_comb begin
    flags_d = flags_q;
    if (!bus.flush) begin
      if (accept && !is_mul) begin
        if (bus.flag_we && !is_nop) flags_d = {alu_c, alu_res[DATA_W-1], alu_res == '0};
        flags_d = flags_d & ~clr_now;
      end else if (mul_done) begin
        if (mul_fwe_q) flags_d[1:0] = {prod[2*DATA_W-1], prod == '0};
        flags_d = flags_d & ~mul_clr_q;
      end
      if (bus.flag_restore) flags_d = bus.flag_restore_val;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      flags_q      <= '0;
      out_valid_q  <= 1'b0;
      result_q     <= '0;
      result_hi_q  <= '0;
      taken_q      <= 1'b0;
      target_q     <= '0;
      pc_q         <= '0;
      ctrl_q       <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_fwe_q    <= 1'b0;
      mul_taken_q  <= 1'b0;
      mul_clr_q    <= '0;
      mul_target_q <= '0;
      mul_pc_q     <= '0;
      mul_ctrl_q   <= '0;
    end else begin
      flags_q <= flags_d;
      if (bus.flush) begin
        out_valid_q <= 1'b0;
        taken_q     <= 1'b0;
        state_q     <= S_IDLE;
        cnt_q       <= '0;
      end else if (accept && !is_mul) begin
        out_valid_q <= 1'b1;
        result_q    <= alu_res;
        result_hi_q <= '0;
        taken_q     <= taken;
        target_q    <= PC_W'(opa);
        pc_q        <= bus.pc;
        ctrl_q      <= bus.ctrl_in;
      end else if (accept) begin
        // Branch is resolved now against pre-instruction flags; the clear lands with the product.
        state_q      <= S_MUL;
        cnt_q        <= CNT_W'(MUL_LAT - 1);
        mul_a_q      <= opa;
        mul_b_q      <= opb;
        mul_fwe_q    <= bus.flag_we;
        mul_taken_q  <= taken;
        mul_clr_q    <= clr_now;
        mul_target_q <= PC_W'(opa);
        mul_pc_q     <= bus.pc;
        mul_ctrl_q   <= bus.ctrl_in;
        if (out_valid_q && bus.out_ready) begin
          out_valid_q <= 1'b0;
          taken_q     <= 1'b0;
        end
      end else if (mul_done) begin
        state_q     <= S_IDLE;
        out_valid_q <= 1'b1;
        result_q    <= prod[DATA_W-1:0];
        result_hi_q <= prod[2*DATA_W-1:DATA_W];
        taken_q     <= mul_taken_q;
        target_q    <= mul_target_q;
        pc_q        <= mul_pc_q;
        ctrl_q      <= mul_ctrl_q;
      end else begin
        if ((state_q == S_MUL) && (cnt_q != '0)) cnt_q <= cnt_q - CNT_W'(1);
        if (out_valid_q && bus.out_ready) begin
          out_valid_q <= 1'b0;
          taken_q     <= 1'b0;
        end
      end
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid_q;
  assign bus.result_out    = result_q;
  assign bus.result_hi_out = result_hi_q;
  assign bus.flags_out     = flags_q;
  assign bus.branch_taken  = taken_q;
  assign bus.branch_target = target_q;
  assign bus.pc_out        = pc_q;
  assign bus.ctrl_out      = ctrl_q;
  assign bus.busy          = (state_q == S_MUL);
endmodule
